// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, fetches over a valid/ack
// handshake and queues {instr, pc+4} pairs for IF/ID, emitting a NOP when empty.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        instr_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      fpc_q, fpc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc4_mem_q   [DEPTH];
  logic             push, pop;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  // Request depends only on registered occupancy plus reset/redirect, never on stall or ack.
  assign imem_req    = !reset && !redirect && (count_q != FULL_CNT);
  assign imem_addr   = fpc_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign pc4_out     = instr_valid ? pc4_mem_q[rd_ptr_q]   : 32'h0;

  assign push = imem_req && imem_ack;
  assign pop  = instr_valid && !stall && !redirect;

  always_comb begin
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      // Flush wins over any ack or pop in the same cycle.
      fpc_d    = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fpc_d    = fpc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PTR_W+1)'(1);
      end else if (!push && pop) begin
        count_d = count_q - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc4_mem_q[wr_ptr_q]   <= fpc_q + 32'd4;
    end
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch stage sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word fetches to an instruction memory over a valid/ack handshake. Fetched instructions are held with their PC+4 in a small FIFO and presented to IF/ID as an instruction/next-PC pair. The FIFO decouples memory latency from pipeline stalls, is flushed on branch/jump redirect, and outputs a NOP (all zeros) whenever it is empty.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch byte address, equals the current fetch PC
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle
- imem_rdata  in  32  instruction word
- stall  in  1  IF/ID is holding; head entry must not be consumed
- redirect  in  1  taken branch/jump resolved; flush and refetch
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0
- instr_out  out  32  head instruction; 32'h0 when empty
- pc4_out  out  32  head PC+4; 32'h0 when empty
- instr_valid  out  1  FIFO non-empty

## Operation
- State: fetch PC `fpc`; FIFO storage of DEPTH x {instr[31:0], pc4[31:0]}; read/write pointers of log2(DEPTH) bits; count of log2(DEPTH)+1 bits.
- imem_req = !reset && !redirect && (count < DEPTH). imem_req depends only on registered state, reset and redirect. It has no path from stall.
- imem_addr = fpc at all times.
- Fetch accept: imem_req && imem_ack. Push {imem_rdata, fpc+4}, then fpc <= fpc+4. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- Pop: instr_valid && !stall. The read pointer advances.
- Push and pop in the same cycle: count is unchanged and both pointers advance. A push at full cannot occur because imem_req is low.
- Pointers wrap modulo DEPTH.
- Output path is combinational from the FIFO head. When count==0, instr_out and pc4_out are forced to 0 (NOP) and instr_valid=0.
- Redirect has the highest priority below reset:
  - count <= 0 and pointers <= 0.
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - Any imem_ack in that cycle is ignored; no push and no fpc increment occur.
  - stall is ignored during redirect, since the flush discards the head.
- Reset: fpc <= RESET_PC, count and pointers <= 0. Reset overrides redirect and ack. Asserting reset mid-fetch discards all buffered entries.

## Timing
- Reset values, visible in the cycle after reset is sampled high and while it is held: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc4_out=0.
- Fetch accepted at edge N: the entry is visible on instr_out/pc4_out after edge N, and instr_valid=1 in cycle N+1 if the FIFO was empty.
- Zero-wait memory (ack tied high) with no stall sustains one instruction per cycle.
- Redirect sampled at edge N: in cycle N+1, instr_valid=0, imem_addr=redirect_pc (aligned) and imem_req=1. The first target instruction is at the output in cycle N+2 if acked in N+1.
- Stall held with ack high: the FIFO fills to DEPTH, then imem_req drops. When stall releases, imem_req reasserts in the cycle after the first pop.
- No combinational path from stall or imem_ack to imem_req.

## Test plan
- **Reset then free-run.** Stimulus: RESET_PC=0, ack=1, stall=0, memory returns word = address. Required: instr_out sequence 0x0,0x4,0x8…; pc4_out = instr_out+4; instr_valid high from the 2nd cycle after reset release.
- **Stall fill.** Stimulus: stall=1 from reset, ack=1. Required: exactly 4 accepts, count=4, imem_req=0, imem_addr=0x10, instr_out=0x0 held. Release stall: 0x0,0x4,0x8,0xC pop on consecutive cycles, and fetch resumes at 0x10.
- **Redirect with data in flight.** Stimulus: FIFO holds 2 entries and ack=1 in the same cycle that redirect=1, redirect_pc=0x0000_0103. Required: next cycle instr_valid=0 and imem_addr=0x100. The acked word is never output. First output is the word at 0x100 with pc4_out=0x104.
- **Slow memory.** Stimulus: ack pulses every 3rd cycle, stall=0. Required: imem_addr is held stable until acked; instr_valid toggles; no duplicated or skipped addresses.
- **Wrap and reset mid-operation.** Stimulus: redirect to 0xFFFF_FFF8 with ack=1. Required: outputs at 0xFFFF_FFF8 (pc4 0xFFFF_FFFC) and 0xFFFF_FFFC (pc4 0x0), then fetch at 0x0. Stimulus: assert reset with 3 entries buffered. Required: next cycle all outputs 0 and imem_addr=RESET_PC.
